// File: rtl/maze_game_ctrl_pkg.sv
// Shared types and constants for the maze game-flow controller.
package maze_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } game_state_e;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_P     = 8'h13;

    localparam int         DEF_FRAMES_PER_SEC = 60;
    localparam logic [7:0] DEF_TIME_LIMIT     = 8'd90;

    function automatic logic is_move_key(input logic [7:0] k);
        return (k == KEY_A) || (k == KEY_D) || (k == KEY_S) || (k == KEY_W);
    endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Signal bundle between the game controller and keyboard/ball/HUD side.
interface maze_game_ctrl_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [7:0] keycode_out;
    logic       ball_reset;
    logic       ended;
    logic [7:0] time_left;
    logic       won;
    logic       lost;
    logic [1:0] state;

    modport master (
        input  frame_clk, keycode, BallX, BallY,
        output keycode_out, ball_reset, ended, time_left, won, lost, state
    );

    modport slave (
        output frame_clk, keycode, BallX, BallY,
        input  keycode_out, ball_reset, ended, time_left, won, lost, state
    );
endinterface

// File: rtl/maze_game_ctrl_frame_tick_sync.sv
// Brings the VSync-rate frame_clk into the Clk domain as a one-cycle tick.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic sync1, sync2, sync3;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            tick  <= sync2 & ~sync3;
        end
    end
endmodule

// File: rtl/maze_game_ctrl.sv
// Round sequencer for the VGA maze: key gating, countdown, pickup/exit outcome.
// Optional feature: define MAZE_PAUSE_EN to add a 'P'-toggled pause inside PLAY.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int         FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter logic [7:0] TIME_LIMIT     = DEF_TIME_LIMIT,
    parameter logic [9:0] PICK_X1        = 10'd600,
    parameter logic [9:0] PICK_X2        = 10'd630,
    parameter logic [9:0] PICK_Y1        = 10'd440,
    parameter logic [9:0] PICK_Y2        = 10'd470,
    parameter logic [9:0] EXIT_Y         = 10'd8
) (
    input logic            Clk,
    input logic            Reset,
    maze_game_ctrl_if.master bus
);
    localparam int FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic tick;

    frame_tick_sync u_frame_tick_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (bus.frame_clk),
        .tick      (tick)
    );

    game_state_e    state_q, state_d;
    logic [7:0]     kc_q;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]     time_left_q, time_left_d;
    logic           ended_q, ended_d;
    logic           ball_reset_q, ball_reset_d;
    logic [7:0]     kc_out_q, kc_out_d;
    logic           won_q, won_d, lost_q, lost_d;
    logic           start_press, in_pick;
    logic           paused_q;

`ifdef MAZE_PAUSE_EN
    logic paused_d, p_press;
    assign p_press = (bus.keycode == KEY_P) && (kc_q != KEY_P);
`else
    assign paused_q = 1'b0;
`endif

    assign start_press = (bus.keycode == KEY_SPACE) && (kc_q != KEY_SPACE);
    assign in_pick     = (bus.BallX >= PICK_X1) && (bus.BallX <= PICK_X2) &&
                         (bus.BallY >= PICK_Y1) && (bus.BallY <= PICK_Y2);

    // Output flags are registered from the current state, so they trail
    // the state register by one Clk and ball_reset/forwarding switch together.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        time_left_d  = time_left_q;
        ended_d      = ended_q;
        ball_reset_d = (state_q == ST_IDLE);
        kc_out_d     = '0;
        won_d        = (state_q == ST_WIN);
        lost_d       = (state_q == ST_LOSE);
`ifdef MAZE_PAUSE_EN
        paused_d     = paused_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                frame_cnt_d = '0;
                time_left_d = TIME_LIMIT;
                ended_d     = 1'b0;
`ifdef MAZE_PAUSE_EN
                paused_d    = 1'b0;
`endif
                if (start_press) state_d = ST_PLAY;
            end
            ST_PLAY: begin
`ifdef MAZE_PAUSE_EN
                if (p_press) paused_d = ~paused_q;
`endif
                if (!paused_q) begin
                    if (is_move_key(bus.keycode)) kc_out_d = bus.keycode;
                    if (in_pick) ended_d = 1'b1;
                    if (tick) begin
                        if (frame_cnt_q == FCW'(FRAMES_PER_SEC - 1)) begin
                            frame_cnt_d = '0;
                            if (time_left_q != '0) time_left_d = time_left_q - 8'd1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                        end
                    end
                    if (ended_q && (bus.BallY < EXIT_Y)) state_d = ST_WIN;
                    else if (time_left_q == '0)          state_d = ST_LOSE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start_press) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            kc_q         <= '0;
            frame_cnt_q  <= '0;
            time_left_q  <= TIME_LIMIT;
            ended_q      <= 1'b0;
            ball_reset_q <= 1'b1;
            kc_out_q     <= '0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            kc_q         <= bus.keycode;
            frame_cnt_q  <= frame_cnt_d;
            time_left_q  <= time_left_d;
            ended_q      <= ended_d;
            ball_reset_q <= ball_reset_d;
            kc_out_q     <= kc_out_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
        end
    end

`ifdef MAZE_PAUSE_EN
    always_ff @(posedge Clk) begin
        if (Reset) paused_q <= 1'b0;
        else       paused_q <= paused_d;
    end
`endif

    assign bus.state       = state_q;
    assign bus.keycode_out = kc_out_q;
    assign bus.ball_reset  = ball_reset_q;
    assign bus.ended       = ended_q;
    assign bus.time_left   = time_left_q;
    assign bus.won         = won_q;
    assign bus.lost        = lost_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Randomized bench for maze_game_ctrl against a round-level reference model.
module tb_maze_game_ctrl;

    localparam int FPS    = 60;
    localparam int TL     = 90;
    localparam int EXIT_Y = 8;
    localparam int PX1 = 600, PX2 = 630, PY1 = 440, PY2 = 470;
`ifdef MAZE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    maze_game_ctrl_if bus ();

    maze_game_ctrl #(
        .FRAMES_PER_SEC (FPS),
        .TIME_LIMIT     (8'(TL)),
        .PICK_X1        (10'(PX1)),
        .PICK_X2        (10'(PX2)),
        .PICK_Y1        (10'(PY1)),
        .PICK_Y2        (10'(PY2)),
        .EXIT_Y         (10'(EXIT_Y))
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: round phase (0 idle, 1 play, 2 win, 3 lose), ticks
    // consumed while live, and the registered flags expected after each edge.
    int         m_st = 0;
    int         m_ticks = 0;
    bit         m_ended = 0, m_paused = 0, m_last_tick = 0;
    bit         m_ball_reset = 1, m_won = 0, m_lost = 0;
    logic [7:0] m_kc_out = '0, m_prev_kc = '0;
    bit         hist [4] = '{default: 1'b0};

    bit fc_run = 0, fc_level = 0;
    int fc_cnt = 0;

    function automatic int tl_now();
        int t = TL - m_ticks / FPS;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit is_move(input logic [7:0] k);
        return k == 8'h04 || k == 8'h07 || k == 8'h16 || k == 8'h1A;
    endfunction

    task automatic model_edge(input bit rst, input logic [7:0] kc, input int bx, input int by, input bit fc);
        bit tk, start, pk, live, inrect;
        int nst;
        if (rst) begin
            m_st = 0; m_ticks = 0; m_ended = 0; m_paused = 0; m_last_tick = 0;
            m_ball_reset = 1; m_won = 0; m_lost = 0; m_kc_out = '0; m_prev_kc = '0;
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            return;
        end
        tk     = hist[2] && !hist[3];
        start  = (kc == 8'h2C) && (m_prev_kc != 8'h2C);
        pk     = PAUSE_EN && (kc == 8'h13) && (m_prev_kc != 8'h13);
        live   = (m_st == 1) && !m_paused;
        inrect = bx >= PX1 && bx <= PX2 && by >= PY1 && by <= PY2;
        m_ball_reset = (m_st == 0);
        m_won        = (m_st == 2);
        m_lost       = (m_st == 3);
        m_kc_out     = (live && is_move(kc)) ? kc : 8'h00;
        m_last_tick  = live && tk;
        nst = m_st;
        case (m_st)
            0: begin
                m_ended = 0; m_ticks = 0; m_paused = 0;
                if (start) nst = 1;
            end
            1: begin
                if (live) begin
                    if (m_ended && by < EXIT_Y) nst = 2;
                    else if (tl_now() == 0)     nst = 3;
                    if (inrect) m_ended = 1;
                    if (tk) m_ticks++;
                end
                if (pk) m_paused = !m_paused;
            end
            default: if (start) nst = 0;
        endcase
        m_st = nst;
        m_prev_kc = kc;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = fc;
    endtask

    task automatic compare_all();
        check("state",       bus.state,       m_st);
        check("ball_reset",  bus.ball_reset,  m_ball_reset);
        check("keycode_out", bus.keycode_out, m_kc_out);
        check("ended",       bus.ended,       m_ended);
        check("time_left",   bus.time_left,   tl_now());
        check("won",         bus.won,         m_won);
        check("lost",        bus.lost,        m_lost);
    endtask

    task automatic step(input logic [7:0] kc, input int bx, input int by, input bit rst = 1'b0);
        @(negedge Clk);
        if (!fc_run) fc_level = 1'b0;
        else begin
            if (fc_cnt == 0) begin
                fc_level = !fc_level;
                fc_cnt   = fc_level ? $urandom_range(1, 2) : $urandom_range(1, 3);
            end
            fc_cnt--;
        end
        Reset         = rst;
        bus.keycode   = kc;
        bus.BallX     = 10'(bx);
        bus.BallY     = 10'(by);
        bus.frame_clk = fc_level;
        @(posedge Clk);
        #1;
        model_edge(rst, kc, bx, by, fc_level);
        compare_all();
    endtask

    function automatic logic [7:0] rand_any_key();
        case ($urandom_range(0, 7))
            0: return 8'h04;
            1: return 8'h07;
            2: return 8'h16;
            3: return 8'h1A;
            4: return 8'h2C;
            5: return 8'h13;
            6: return 8'h05;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [7:0] rand_move_key();
        case ($urandom_range(0, 5))
            0: return 8'h04;
            1: return 8'h07;
            2: return 8'h16;
            3: return 8'h1A;
            4: return 8'h05;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int starts, n, cnt, tl_before;
        logic [1:0] prev;
        Reset = 1'b1; bus.keycode = '0; bus.BallX = '0; bus.BallY = 10'd100; bus.frame_clk = 1'b0;

        repeat (3) step(8'h00, 100, 100, 1'b1);
        check("rst_time_left", bus.time_left, TL);
        check("rst_ball_reset", bus.ball_reset, 1);

        // Held space must start exactly one round
        starts = 0;
        prev = bus.state;
        for (int i = 0; i < 10; i++) begin
            step(8'h2C, 100, 100);
            if (prev == 2'd0 && bus.state == 2'd1) starts++;
            prev = bus.state;
        end
        check("single_start", starts, 1);
        check("ball_reset_low", bus.ball_reset, 0);
        check("play_time_left", bus.time_left, TL);
        step(8'h1A, 100, 100);
        check("fwd_w", bus.keycode_out, 8'h1A);
        step(8'h05, 100, 100);
        check("block_05", bus.keycode_out, 8'h00);

        // Random play away from the pickup zone, then run the clock out
        fc_run = 1;
        repeat (300) step(rand_any_key(), $urandom_range(0, 599), $urandom_range(8, 479));
        if (m_paused) begin step(8'h00, 100, 100); step(8'h13, 100, 100); end
        n = 0;
        while (m_st == 1 && n < 30000) begin
            step(rand_move_key(), $urandom_range(0, 599), $urandom_range(8, 479));
            n++;
        end
        check("lose_reached", bus.state, 3);
        step(8'h04, 100, 100);
        check("lost_flag", bus.lost, 1);
        check("lose_kc_out", bus.keycode_out, 8'h00);
        check("lose_time_left", bus.time_left, 0);

        // Win round: pickup then exit
        step(8'h00, 100, 100); step(8'h2C, 100, 100); step(8'h00, 100, 100); step(8'h2C, 100, 100);
        check("restart_play", bus.state, 1);
        repeat (50) step(rand_move_key(), $urandom_range(0, 599), $urandom_range(8, 479));
        step(8'h07, 615, 455); step(8'h07, 615, 455);
        check("ended_set", bus.ended, 1);
        repeat (50) step(rand_move_key(), $urandom_range(0, 639), $urandom_range(8, 479));
        step(8'h1A, 320, 5);
        check("win_state", bus.state, 2);
        repeat (3) step(rand_move_key(), 320, 5);
        check("won_flag", bus.won, 1);
        check("ended_held", bus.ended, 1);
        step(8'h2C, 320, 5);
        step(8'h00, 100, 100);
        check("ended_cleared", bus.ended, 0);

        // Exit reached in the same cycle the timer expires
        step(8'h2C, 100, 100);
        step(8'h00, 615, 455); step(8'h00, 615, 455);
        n = 0;
        while (tl_now() != 0 && n < 30000) begin
            step(rand_move_key(), 100, 100);
            n++;
        end
        check("prio_timer_zero", bus.time_left, 0);
        step(8'h00, 100, 5);
        check("win_priority", bus.state, 2);

        // Mid-round reset discards progress
        step(8'h2C, 100, 100); step(8'h00, 100, 100); step(8'h2C, 100, 100);
        step(8'h00, 615, 455); step(8'h00, 615, 455);
        repeat (40) step(rand_move_key(), 100, 100);
        step(8'h00, 100, 100, 1'b1);
        check("midrst_state", bus.state, 0);
        check("midrst_ended", bus.ended, 0);
        check("midrst_time_left", bus.time_left, TL);
        step(8'h00, 100, 100);
        check("midrst_ball_reset", bus.ball_reset, 1);

`ifdef MAZE_PAUSE_EN
        step(8'h2C, 100, 100); step(8'h00, 100, 100);
        step(8'h13, 100, 100);
        tl_before = bus.time_left;
        cnt = 0; n = 0;
        while (cnt < 120 && n < 5000) begin
            step(($urandom_range(0, 7) == 0) ? 8'h2C : rand_move_key(), 615, 455);
            if (hist[2] && !hist[3]) cnt++;
            n++;
        end
        check("pause_ticks_seen", cnt, 120);
        step(8'h04, 615, 455);
        check("pause_frozen", bus.time_left, tl_before);
        check("pause_kc_out", bus.keycode_out, 8'h00);
        check("pause_no_pickup", bus.ended, 0);
        check("pause_state", bus.state, 1);
        step(8'h00, 100, 100); step(8'h13, 100, 100); step(8'h04, 100, 100);
        check("resume_fwd", bus.keycode_out, 8'h04);
`endif

        fc_run = 0;
        repeat (5) step(8'h00, 100, 100);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
